// File: rtl/spi_master_pkg.sv
// spi_master_pkg: controller state encoding and control-write opcodes shared by the SPI master files
package spi_master_pkg;
    typedef enum logic [2:0] {IDLE, CTRL, SETUP, SHIFT, HOLD} state_t;
    localparam logic [7:0] OP_SET_DIV   = 8'h80;
    localparam logic [7:0] OP_SET_3WIRE = 8'h81;
endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: host request/ready port of the SPI master (master = host side, slave = controller side)
interface spi_master_ctrl_if;
    logic [4:0]  nbits;
    logic [31:0] mosi_data;
    logic [31:0] miso_data;
    logic        request;
    logic        ready;
    modport master (output nbits, mosi_data, request, input miso_data, ready);
    modport slave  (input nbits, mosi_data, request, output miso_data, ready);
endinterface

// File: rtl/spi_sck_div.sv
// spi_sck_div: half-period counter generating an idle-high SCK and its fall/rise strobes
module spi_sck_div (
    input  logic        clk_in,
    input  logic        nrst,
    input  logic        en,
    input  logic        hold,
    input  logic [15:0] divcoef,
    output logic        sck,
    output logic        sck_fall,
    output logic        sck_rise
);
    logic [15:0] cnt;
    logic        wrap;

    assign wrap     = en && cnt == divcoef;
    assign sck_fall = wrap && sck;
    assign sck_rise = wrap && !sck;

    // Count 0..divcoef while enabled and toggle SCK at each wrap; hold blocks a fall so SCK parks high
    always_ff @(posedge clk_in or negedge nrst)
        if (!nrst) begin
            cnt <= '0;
            sck <= 1'b1;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b1;
        end else begin
            cnt <= wrap ? 16'd0 : cnt + 16'd1;
            if (wrap && !(hold && sck)) sck <= ~sck;
        end
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-3 SPI master with request/ready host port; macro SPI_3WIRE_EN adds shared-line 3-wire reads
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter logic [15:0] DIV_COEF = 16'd1
) (
    input  logic             clk_in,
    input  logic             nrst,
    spi_master_ctrl_if.slave host,
    output logic             spi_csn,
    output logic             spi_sck,
`ifdef SPI_3WIRE_EN
    inout  wire              spi_mosi,
`else
    output logic             spi_mosi,
`endif
    input  logic             spi_miso
);
    state_t      state, state_nx;
    logic [15:0] divcoef;
    logic [31:0] tx_q, rx;
    logic [4:0]  idx;
    logic        mosi_q, din, sck_fall, sck_rise, accept, active;

    assign accept = state == IDLE && host.request;
    assign active = state inside {SETUP, SHIFT, HOLD};

    spi_sck_div u_div (
        .clk_in   (clk_in),
        .nrst     (nrst),
        .en       (active),
        .hold     (state == HOLD),
        .divcoef  (divcoef),
        .sck      (spi_sck),
        .sck_fall (sck_fall),
        .sck_rise (sck_rise)
    );

    // State register
    always_ff @(posedge clk_in or negedge nrst)
        if (!nrst) state <= IDLE;
        else       state <= state_nx;

    // Next state: SETUP ends on the first SCK fall, SHIFT on the last rise, HOLD one half-period later
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (host.request) state_nx = host.nbits == 5'd0 ? CTRL : SETUP;
            CTRL:    state_nx = IDLE;
            SETUP:   if (sck_fall) state_nx = SHIFT;
            SHIFT:   if (sck_rise && idx == 5'd0) state_nx = HOLD;
            HOLD:    if (sck_fall) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch the request, drive on SCK fall, sample on SCK rise, publish the word when HOLD ends
    always_ff @(posedge clk_in or negedge nrst)
        if (!nrst) begin
            host.ready     <= 1'b1;
            host.miso_data <= '0;
            spi_csn        <= 1'b1;
            mosi_q         <= 1'b0;
            divcoef        <= DIV_COEF;
            tx_q           <= '0;
            rx             <= '0;
            idx            <= '0;
        end else begin
            host.ready <= state_nx == IDLE;
            spi_csn    <= !(state_nx inside {SETUP, SHIFT, HOLD});
            if (accept) begin
                tx_q <= host.mosi_data;
                idx  <= host.nbits;
                rx   <= '0;
            end
            if (state == CTRL && tx_q[31:24] == OP_SET_DIV) divcoef <= tx_q[15:0];
            if (state inside {SETUP, SHIFT} && sck_fall) mosi_q <= tx_q[idx];
            if (state == SHIFT && sck_rise) begin
                rx  <= {rx[30:0], din};
                idx <= idx - 5'd1;
            end
            if (state == HOLD && sck_fall) begin
                host.miso_data <= rx;
                mosi_q         <= 1'b0;
            end
        end

`ifdef SPI_3WIRE_EN
    logic [4:0] nbits_q;
    logic       threewire, oe, rd_in;

    assign rd_in    = threewire && tx_q[nbits_q] && 5'(nbits_q - idx) >= 5'd8;
    assign din      = rd_in ? spi_mosi : spi_miso;
    assign spi_mosi = oe ? mosi_q : 1'bz;

    // Wire mode and data-line direction: a 3-wire read releases the line after the 8-bit command
    always_ff @(posedge clk_in or negedge nrst)
        if (!nrst) begin
            nbits_q   <= '0;
            threewire <= 1'b0;
            oe        <= 1'b1;
        end else begin
            if (accept) nbits_q <= host.nbits;
            if (state == CTRL && tx_q[31:24] == OP_SET_3WIRE) threewire <= tx_q[16];
            if (accept || (state == HOLD && sck_fall)) oe <= 1'b1;
            else if (state inside {SETUP, SHIFT} && sck_fall && rd_in) oe <= 1'b0;
        end
`else
    assign din      = spi_miso;
    assign spi_mosi = mosi_q;
`endif
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl with loopback and a LIS3DH-style slave model
module tb_spi_master_ctrl;
    logic        clk_in = 1'b0;
    logic        nrst = 1'b0;
    wire         spi_mosi;
    logic        spi_csn, spi_sck, spi_miso;
    int          errors = 0, checks = 0, cyc = 0, busy = 0;
    int          csn_falls = 0, sck_rises = 0, period = 0, last_rise = 0, xfer_id = -1, slot = 0;
    logic [31:0] cap = '0;
    logic        loop_en = 1'b0, mode3 = 1'b0, miso_q = 1'b0;
    logic [7:0]  resp = 8'h33;
`ifdef SPI_3WIRE_EN
    logic        sl_rd = 1'b0, sl_bit = 1'b0;
    int          sl_id = -1;
`endif

    spi_master_ctrl_if host();

    spi_master_ctrl #(.DIV_COEF(16'd1)) dut (
        .clk_in   (clk_in),
        .nrst     (nrst),
        .host     (host),
        .spi_csn  (spi_csn),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;
    always @(negedge spi_csn) csn_falls++;

    // Slave capture: MOSI stream, SCK pulse count and SCK period in clk_in cycles
    always @(posedge spi_sck) begin
        cap = {cap[30:0], spi_mosi};
        sck_rises++;
        period = cyc - last_rise;
        last_rise = cyc;
    end

    // Slave response: 0x33 in bit slots 8..15 of each frame, driven on SCK fall
    always @(negedge spi_sck) begin
        slot = (xfer_id == csn_falls) ? slot + 1 : 0;
        xfer_id = csn_falls;
        miso_q = mode3 ? 1'b1 : (slot >= 8 && slot < 16) ? resp[15 - slot] : 1'b0;
`ifdef SPI_3WIRE_EN
        if (slot == 8) begin
            sl_rd = mode3 && cap[7];
            sl_id = csn_falls;
        end
        sl_bit = (slot >= 8 && slot < 16) ? resp[15 - slot] : 1'b0;
`endif
    end

    assign spi_miso = loop_en ? spi_mosi : miso_q;
`ifdef SPI_3WIRE_EN
    assign spi_mosi = (!spi_csn && sl_rd && sl_id == csn_falls) ? sl_bit : 1'bz;
`endif

    task automatic wait_idle();
        busy = 0;
        while (host.ready !== 1'b1 && busy < 2000) begin
            busy++;
            @(posedge clk_in); #1;
        end
        if (host.ready !== 1'b1) begin
            errors++; checks++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, expected 1", host.ready, busy);
        end
    endtask

    task automatic xfer(input logic [4:0] nb, input logic [31:0] d);
        @(posedge clk_in); #1;
        host.nbits = nb; host.mosi_data = d; host.request = 1'b1;
        @(posedge clk_in); #1;
        host.request = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        host.request = 1'b0; host.nbits = '0; host.mosi_data = '0;
        nrst = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        checks++; if (spi_csn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b, expected 1", spi_csn); end
        checks++; if (spi_sck !== 1'b1) begin errors++; $display("FAIL reset_sck: got %b, expected 1", spi_sck); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b, expected 0", spi_mosi); end
        checks++; if (host.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", host.ready); end
        checks++; if (host.miso_data !== 32'h0) begin errors++; $display("FAIL reset_miso: got %h, expected 0", host.miso_data); end
        nrst = 1'b1;
    endtask

    task automatic test_loopback();
        int r0, c0;
        loop_en = 1'b1; r0 = sck_rises; c0 = csn_falls;
        xfer(5'd7, 32'hA5);
        checks++; if (host.miso_data !== 32'hA5) begin errors++; $display("FAIL lb_miso: got %h, expected a5", host.miso_data); end
        checks++; if (sck_rises - r0 !== 8) begin errors++; $display("FAIL lb_pulses: got %0d, expected 8", sck_rises - r0); end
        checks++; if (period !== 4) begin errors++; $display("FAIL lb_period: got %0d, expected 4", period); end
        checks++; if (cap[7:0] !== 8'hA5) begin errors++; $display("FAIL lb_mosi: got %h, expected a5", cap[7:0]); end
        checks++; if (busy !== 34) begin errors++; $display("FAIL lb_busy: got %0d, expected 34", busy); end
        checks++; if (csn_falls - c0 !== 1) begin errors++; $display("FAIL lb_csn: got %0d, expected 1", csn_falls - c0); end
    endtask

    task automatic test_ctrl_div();
        int r0, c0;
        r0 = sck_rises; c0 = csn_falls;
        xfer(5'd0, 32'h8080_0000);
        checks++; if (busy !== 1) begin errors++; $display("FAIL ctrl_busy: got %0d, expected 1", busy); end
        checks++; if (csn_falls - c0 !== 0) begin errors++; $display("FAIL ctrl_csn: got %0d, expected 0", csn_falls - c0); end
        checks++; if (sck_rises - r0 !== 0) begin errors++; $display("FAIL ctrl_sck: got %0d, expected 0", sck_rises - r0); end
        checks++; if (host.miso_data !== 32'hA5) begin errors++; $display("FAIL ctrl_miso: got %h, expected a5", host.miso_data); end
        xfer(5'd7, 32'h3C);
        checks++; if (period !== 2) begin errors++; $display("FAIL div0_period: got %0d, expected 2", period); end
        checks++; if (host.miso_data !== 32'h3C) begin errors++; $display("FAIL div0_miso: got %h, expected 3c", host.miso_data); end
        checks++; if (busy !== 17) begin errors++; $display("FAIL div0_busy: got %0d, expected 17", busy); end
    endtask

    task automatic test_lis3dh();
        int r0;
        loop_en = 1'b0; r0 = sck_rises;
        xfer(5'd15, 32'h8F00);
        checks++; if (sck_rises - r0 !== 16) begin errors++; $display("FAIL lis_pulses: got %0d, expected 16", sck_rises - r0); end
        checks++; if (cap[15:0] !== 16'h8F00) begin errors++; $display("FAIL lis_mosi: got %h, expected 8f00", cap[15:0]); end
        checks++; if (host.miso_data[7:0] !== 8'h33) begin errors++; $display("FAIL lis_whoami: got %h, expected 33", host.miso_data[7:0]); end
        checks++; if (host.miso_data !== 32'h33) begin errors++; $display("FAIL lis_word: got %h, expected 00000033", host.miso_data); end
    endtask

    task automatic test_max_len();
        int r0;
        xfer(5'd0, 32'h5500_FFFF);
        loop_en = 1'b1; r0 = sck_rises;
        xfer(5'd31, 32'hDEAD_BEEF);
        checks++; if (host.miso_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL max_miso: got %h, expected deadbeef", host.miso_data); end
        checks++; if (sck_rises - r0 !== 32) begin errors++; $display("FAIL max_pulses: got %0d, expected 32", sck_rises - r0); end
        checks++; if (period !== 2) begin errors++; $display("FAIL max_period: got %0d, expected 2", period); end
        checks++; if (busy !== 65) begin errors++; $display("FAIL max_busy: got %0d, expected 65", busy); end
    endtask

    task automatic test_busy_ignored();
        int c0;
        xfer(5'd0, 32'h8000_0003);
        c0 = csn_falls;
        @(posedge clk_in); #1;
        host.nbits = 5'd3; host.mosi_data = 32'h9; host.request = 1'b1;
        repeat (3) begin @(posedge clk_in); #1; end
        host.request = 1'b0;
        repeat (5) begin @(posedge clk_in); #1; end
        host.nbits = 5'd0; host.mosi_data = 32'h8000_0000; host.request = 1'b1;
        @(posedge clk_in); #1;
        host.request = 1'b0;
        wait_idle();
        checks++; if (csn_falls - c0 !== 1) begin errors++; $display("FAIL held_csn: got %0d, expected 1", csn_falls - c0); end
        checks++; if (host.miso_data !== 32'h9) begin errors++; $display("FAIL held_miso: got %h, expected 9", host.miso_data); end
        checks++; if (period !== 8) begin errors++; $display("FAIL held_period: got %0d, expected 8", period); end
        xfer(5'd3, 32'h6);
        checks++; if (host.miso_data !== 32'h6) begin errors++; $display("FAIL after_miso: got %h, expected 6", host.miso_data); end
        checks++; if (period !== 8) begin errors++; $display("FAIL after_period: got %0d, expected 8", period); end
        checks++; if (busy !== 36) begin errors++; $display("FAIL after_busy: got %0d, expected 36", busy); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk_in); #1;
        host.nbits = 5'd31; host.mosi_data = 32'hFFFF_0000; host.request = 1'b1;
        @(posedge clk_in); #1;
        host.request = 1'b0;
        repeat (21) @(posedge clk_in);
        #3 nrst = 1'b0;
        #1;
        checks++; if (spi_csn !== 1'b1) begin errors++; $display("FAIL abort_csn: got %b, expected 1", spi_csn); end
        checks++; if (spi_sck !== 1'b1) begin errors++; $display("FAIL abort_sck: got %b, expected 1", spi_sck); end
        checks++; if (host.ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, expected 1", host.ready); end
        checks++; if (host.miso_data !== 32'h0) begin errors++; $display("FAIL abort_miso: got %h, expected 0", host.miso_data); end
        @(posedge clk_in); #3 nrst = 1'b1;
        xfer(5'd7, 32'h5A);
        checks++; if (host.miso_data !== 32'h5A) begin errors++; $display("FAIL rerun_miso: got %h, expected 5a", host.miso_data); end
        checks++; if (period !== 4) begin errors++; $display("FAIL rerun_period: got %0d, expected 4", period); end
    endtask

`ifdef SPI_3WIRE_EN
    task automatic test_3wire();
        loop_en = 1'b0; mode3 = 1'b0;
        xfer(5'd15, 32'h2301);
        checks++; if (cap[15:0] !== 16'h2301) begin errors++; $display("FAIL w3_write: got %h, expected 2301", cap[15:0]); end
        xfer(5'd0, 32'h8101_0000);
        mode3 = 1'b1;
        xfer(5'd15, 32'h8F00);
        checks++; if (host.miso_data[7:0] !== 8'h33) begin errors++; $display("FAIL w3_read: got %h, expected 33", host.miso_data[7:0]); end
        checks++; if (cap[15:8] !== 8'h8F) begin errors++; $display("FAIL w3_cmd: got %h, expected 8f", cap[15:8]); end
        xfer(5'd0, 32'h8100_0000);
        mode3 = 1'b0;
        xfer(5'd15, 32'h8F00);
        checks++; if (host.miso_data !== 32'h33) begin errors++; $display("FAIL w4_read: got %h, expected 00000033", host.miso_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_ctrl_div();
        test_lis3dh();
        test_max_len();
        test_busy_ignored();
        test_reset_mid();
`ifdef SPI_3WIRE_EN
        test_3wire();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
